// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : memory-op codes, exception bit indices and MEM FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int EXP_W    = 14;
  localparam int EXP_ADEL = 4;
  localparam int EXP_ADES = 5;

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LB   = 4'd1;
  localparam logic [3:0] MOP_LBU  = 4'd2;
  localparam logic [3:0] MOP_LH   = 4'd3;
  localparam logic [3:0] MOP_LHU  = 4'd4;
  localparam logic [3:0] MOP_LW   = 4'd5;
  localparam logic [3:0] MOP_SB   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_formatter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_formatter : picks byte/half/word from the bus word and extends it
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_op)
      MOP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      MOP_LBU: o_result = {24'h0, w_byte};
      MOP_LH:  o_result = {{16{w_half[15]}}, w_half};
      MOP_LHU: o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_stage : lane-0 load/store on an SRAM-like bus + MEM/WB register
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_access_stage
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [3:0]       ex_mem_op,
  input  logic [31:0]      ex_out_first,
  input  logic [31:0]      ex_out_second,
  input  logic [31:0]      ex_rt_first,
  input  logic [EXP_W-1:0] ex_exp_first,
  input  logic [EXP_W-1:0] ex_exp_second,
  output logic             data_req,
  output logic             data_wr,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [31:0]      data_rdata,
  output logic             mem_stall,
  output logic             wb_valid,
  output logic [31:0]      wb_out_first,
  output logic [31:0]      wb_out_second,
  output logic [EXP_W-1:0] wb_exp_first,
  output logic [EXP_W-1:0] wb_exp_second,
  output logic [31:0]      wb_badvaddr
);

  mem_state_e       r_state, w_next;
  logic [3:0]       r_op;
  logic             r_wr;
  logic [3:0]       r_be;
  logic [31:0]      r_addr, r_wdata;
  logic             w_is_load, w_is_store, w_misalign, w_accept, w_adel, w_ades;
  logic             w_load_done;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_load_result;
  logic [EXP_W-1:0] w_exp_add;

  assign w_is_load  = is_load(ex_mem_op);
  assign w_is_store = is_store(ex_mem_op);

  always_comb begin
    w_misalign = 1'b0;
    case (ex_mem_op)
      MOP_LH, MOP_LHU, MOP_SH: w_misalign = ex_out_first[0];
      MOP_LW, MOP_SW:          w_misalign = |ex_out_first[1:0];
      default:                 w_misalign = 1'b0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && ex_valid && (w_is_load || w_is_store) &&
                    (ex_exp_first == '0) && !w_misalign && !flush;
  assign w_adel   = ex_valid && w_is_load  && w_misalign;
  assign w_ades   = ex_valid && w_is_store && w_misalign;

  always_comb begin
    w_exp_add           = '0;
    w_exp_add[EXP_ADEL] = w_adel;
    w_exp_add[EXP_ADES] = w_ades;
  end

  // Little-endian byte lanes; data is replicated so the slave can ignore the offset.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    case (ex_mem_op)
      MOP_SB: begin
        w_be    = 4'b0001 << ex_out_first[1:0];
        w_wdata = {4{ex_rt_first[7:0]}};
      end
      MOP_SH: begin
        w_be    = ex_out_first[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_rt_first[15:0]}};
      end
      MOP_SW:  w_wdata = ex_rt_first;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_REQ;
      ST_REQ: begin
        if (data_addr_ok)  w_next = flush ? ST_DRAIN : ST_WAIT;
        else if (flush)    w_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (data_data_ok)  w_next = ST_IDLE;
        else if (flush)    w_next = ST_DRAIN;
      end
      default:  if (data_data_ok) w_next = ST_IDLE;
    endcase
  end

  assign mem_stall = (r_state == ST_REQ) || (r_state == ST_DRAIN) ||
                     ((r_state == ST_WAIT) && !data_data_ok) ||
                     ((r_state == ST_IDLE) && w_accept);

  assign data_req   = (r_state == ST_REQ);
  assign data_wr    = r_wr;
  assign data_be    = r_be;
  assign data_addr  = {r_addr[31:2], 2'b00};
  assign data_wdata = r_wdata;

  load_formatter u_load_formatter (
    .i_rdata   (data_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_op      (r_op),
    .o_result  (w_load_result)
  );

  assign w_load_done = (r_state == ST_WAIT) && data_data_ok && is_load(r_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= MOP_NONE;
      r_wr    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= ex_mem_op;
        r_wr    <= w_is_store;
        r_be    <= w_be;
        r_addr  <= ex_out_first;
        r_wdata <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_out_first  <= 32'h0;
      wb_out_second <= 32'h0;
      wb_exp_first  <= '0;
      wb_exp_second <= '0;
      wb_badvaddr   <= 32'h0;
    end else if (mem_stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid      <= ex_valid && !flush;
      wb_out_first  <= w_load_done ? w_load_result : ex_out_first;
      wb_out_second <= ex_out_second;
      wb_exp_first  <= ex_exp_first | w_exp_add;
      wb_exp_second <= ex_exp_second;
      wb_badvaddr   <= (w_adel || w_ades) ? ex_out_first : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_stage : directed self-checking bench for mem_access_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_out_first, ex_out_second, ex_rt_first;
  logic [13:0] ex_exp_first, ex_exp_second;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_stall, wb_valid;
  logic [31:0] wb_out_first, wb_out_second, wb_badvaddr;
  logic [13:0] wb_exp_first, wb_exp_second;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid),
    .ex_mem_op(ex_mem_op), .ex_out_first(ex_out_first), .ex_out_second(ex_out_second),
    .ex_rt_first(ex_rt_first), .ex_exp_first(ex_exp_first), .ex_exp_second(ex_exp_second),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_out_first(wb_out_first), .wb_out_second(wb_out_second),
    .wb_exp_first(wb_exp_first), .wb_exp_second(wb_exp_second), .wb_badvaddr(wb_badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; ex_valid = 1'b0; ex_mem_op = MOP_NONE;
    ex_out_first = 32'h0; ex_out_second = 32'h0; ex_rt_first = 32'h0;
    ex_exp_first = '0; ex_exp_second = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  // Accept cycle, addr_ok in first REQ cycle, data_ok one cycle later, WB check.
  task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata,
                        input logic [3:0] be, input logic [31:0] wdata, input logic wr,
                        input logic [31:0] wb_exp);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = op; ex_out_first = addr;
    ex_out_second = ~addr; ex_rt_first = rt;
    #1;
    chk({tag, "_acc_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, "_acc_req"},   32'(data_req),  32'd0);
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk({tag, "_req"},      32'(data_req), 32'd1);
    chk({tag, "_addr"},     data_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"},       32'(data_be), 32'(be));
    chk({tag, "_wr"},       32'(data_wr), 32'(wr));
    if (wr) chk({tag, "_wdata"}, data_wdata, wdata);
    chk({tag, "_bubble"},   32'(wb_valid), 32'd0);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
    #1;
    chk({tag, "_wait_req"},   32'(data_req),  32'd0);
    chk({tag, "_wait_stall"}, 32'(mem_stall), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0; ex_valid = 1'b0; ex_mem_op = MOP_NONE;
    #1;
    chk({tag, "_wb_valid"},  32'(wb_valid), 32'd1);
    chk({tag, "_wb_first"},  wb_out_first, wb_exp);
    chk({tag, "_wb_second"}, wb_out_second, ~addr);
    chk({tag, "_wb_exp"},    32'(wb_exp_first), 32'd0);
  endtask

  task automatic misaligned(input string tag, input logic [3:0] op,
                            input logic [31:0] addr, input logic [13:0] exp_bits);
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = op; ex_out_first = addr;
    #1;
    chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_req"},   32'(data_req),  32'd0);
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_op = MOP_NONE;
    #1;
    chk({tag, "_req2"},     32'(data_req),     32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid),     32'd1);
    chk({tag, "_wb_exp"},   32'(wb_exp_first), 32'(exp_bits));
    chk({tag, "_badva"},    wb_badvaddr,       addr);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_first", wb_out_first, 32'h0);
    chk("rst_req",      32'(data_req), 32'd0);
    chk("rst_be",       32'(data_be),  32'd0);
    chk("rst_addr",     data_addr,     32'h0);
    chk("rst_stall",    32'(mem_stall), 32'd0);
    reset = 1'b0;

    // Non-memory pair: one cycle to WB
    @(negedge clk);
    ex_valid = 1'b1; ex_out_first = 32'h1111_2222; ex_out_second = 32'h3333_4444;
    ex_exp_second = 14'h0003;
    #1;
    chk("alu_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("alu_wb_valid",  32'(wb_valid), 32'd1);
    chk("alu_wb_first",  wb_out_first,  32'h1111_2222);
    chk("alu_wb_second", wb_out_second, 32'h3333_4444);
    chk("alu_wb_exp2",   32'(wb_exp_second), 32'h0003);
    chk("alu_badva",     wb_badvaddr, 32'h0);

    access("lw",  MOP_LW,  32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
    access("sb",  MOP_SB,  32'h2000_0003, 32'h0000_00A5, 32'h0, 4'b1000, 32'hA5A5_A5A5, 1'b1, 32'h2000_0003);
    access("sh",  MOP_SH,  32'h2000_0102, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 1'b1, 32'h2000_0102);
    access("lb",  MOP_LB,  32'h3000_0002, 32'h0, 32'h0080_0000, 4'hF, 32'h0, 1'b0, 32'hFFFF_FF80);
    access("lbu", MOP_LBU, 32'h3000_0002, 32'h0, 32'h0080_0000, 4'hF, 32'h0, 1'b0, 32'h0000_0080);
    access("lh",  MOP_LH,  32'h3000_0012, 32'h0, 32'h8001_0000, 4'hF, 32'h0, 1'b0, 32'hFFFF_8001);
    access("lhu", MOP_LHU, 32'h3000_0010, 32'h0, 32'h1234_C0DE, 4'hF, 32'h0, 1'b0, 32'h0000_C0DE);

    misaligned("adel_lh", MOP_LH, 32'h4000_0001, 14'h0010);
    misaligned("ades_sw", MOP_SW, 32'h4000_0006, 14'h0020);

    // Slave holds addr_ok low for five cycles
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = MOP_LW; ex_out_first = 32'h5000_0008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_req",   32'(data_req),  32'd1);
      chk("hold_addr",  data_addr,      32'h5000_0008);
      chk("hold_be",    32'(data_be),   32'hF);
      chk("hold_stall", 32'(mem_stall), 32'd1);
    end
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("hold_req_last", 32'(data_req), 32'd1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("hold_wb_valid", 32'(wb_valid), 32'd1);
    chk("hold_wb_first", wb_out_first,  32'h0BAD_F00D);

    // Flush while waiting for data: returning data must be dropped
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_op = MOP_LW; ex_out_first = 32'h6000_0000;
    @(negedge clk);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fl_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fl_drain_stall", 32'(mem_stall), 32'd1);
      chk("fl_drain_wbv",   32'(wb_valid),  32'd0);
      @(negedge clk);
    end
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    chk("fl_dok_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fl_after_wbv",   32'(wb_valid),  32'd0);
    chk("fl_after_stall", 32'(mem_stall), 32'd0);
    chk("fl_after_req",   32'(data_req),  32'd0);

    access("lw2", MOP_LW, 32'h7000_0000, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
